pb_bank_ctrl: RTL and testbench

Parametrised controller for a bank of WIDTH bidirectional PB8-style pad cells; it drives each pad's I, OEN and IE pins and conditions each pad's C return. Per channel it adds a registered output path, a direction state machine with a tristate turnaround gap, a synchroniser, a debounce filter and edge detection. The block sits between core GPIO logic and the pad ring, one instance per pad bank.

---
 rtl/pb_bank_ctrl.sv | 117 +++++++++++
 tb/tb_pb_bank_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_bank_ctrl.sv
// pb_bank_ctrl: PB8 pad bank controller with turnaround-guarded direction FSMs,
// input synchroniser, debounce filter and edge detection per channel.
module pb_bank_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4,
  parameter int TURN_CYC    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] oen_req,
  input  logic [WIDTH-1:0] ie,
  input  logic             pg,
  input  logic             deb_en,
  input  logic [DEB_W-1:0] deb_thresh,
  input  logic [WIDTH-1:0] pad_c,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  output logic [WIDTH-1:0] pad_ie,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int TW = TURN_CYC > 1 ? $clog2(TURN_CYC) : 1;
  typedef enum logic [1:0] {IN, TURN, OUT} dir_e;
  logic [WIDTH-1:0] pad_i_q;
  logic [WIDTH-1:0] pad_ie_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic             byp;
  assign s      = sync_q[SYNC_STAGES-1];
  assign byp    = !deb_en || deb_thresh == '0;
  assign pad_i  = pad_i_q;
  assign pad_ie = pad_ie_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_i_q  <= '0;
      pad_ie_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      pad_i_q   <= dout;
      pad_ie_q  <= ie & {WIDTH{pg}};
      sync_q[0] <= pad_c;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    dir_e             st_q;
    logic [TW-1:0]    tcnt_q;
    logic             oen_q;
    logic             din_q;
    logic             din_d;
    logic             rise_q;
    logic             fall_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             hit;
    assign hit = cnt_q == deb_thresh - DEB_W'(1);
    always_comb begin
      din_d = byp || (s[i] != din_q && hit) ? s[i] : din_q;
      cnt_d = byp || s[i] == din_q || hit ? '0 : cnt_q + DEB_W'(1);
    end
    // pad_oen is released on the same edge that leaves OUT, so the pad never drives during TURN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= IN;
        tcnt_q <= '0;
        oen_q  <= 1'b1;
      end else if (!pg) begin
        st_q   <= IN;
        tcnt_q <= '0;
        oen_q  <= 1'b1;
      end else begin
        case (st_q)
          IN: if (!oen_req[i]) begin
            st_q   <= TURN;
            tcnt_q <= '0;
          end
          TURN: if (tcnt_q == TW'(TURN_CYC - 1)) begin
            st_q   <= oen_req[i] ? IN : OUT;
            tcnt_q <= '0;
            oen_q  <= oen_req[i];
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
          OUT: if (oen_req[i]) begin
            st_q   <= TURN;
            tcnt_q <= '0;
            oen_q  <= 1'b1;
          end
          default: begin
            st_q  <= IN;
            oen_q <= 1'b1;
          end
        endcase
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        din_q  <= 1'b0;
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        din_q  <= din_d;
        cnt_q  <= cnt_d;
        rise_q <= din_d & ~din_q;
        fall_q <= ~din_d & din_q;
      end
    end
    assign pad_oen[i] = oen_q;
    assign din[i]     = din_q;
    assign rise[i]    = rise_q;
    assign fall[i]    = fall_q;
  end
endmodule

// File: tb/tb_pb_bank_ctrl.sv
// tb_pb_bank_ctrl: directed and randomised checks of pb_bank_ctrl with TURN_CYC=3 and TURN_CYC=1 instances.
module tb_pb_bank_ctrl;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] dout = 8'hff;
  logic [7:0] oen_req = 8'h00;
  logic [7:0] ie = 8'hff;
  logic       pg = 1;
  logic       deb_en = 0;
  logic [3:0] deb_thresh = 0;
  logic [7:0] pad_c = 0;
  logic [7:0] pi, po, pe, dn, ri, fa;
  logic [7:0] pi1, po1, pe1, dn1, ri1, fa1;
  int n_chk = 0;
  int n_pass = 0;
  int m_st [8];
  int m_tc [8];
  logic [3:0] m_cnt [8];
  logic [7:0] m_oen, m_pi, m_pie, m_din, m_rise, m_fall, m_s0, m_s1;
  int run [8];
  logic [7:0] prev_oen;

  always #5 clk = ~clk;

  pb_bank_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEB_W(4), .TURN_CYC(3)) u3 (
    .clk(clk), .rst(rst), .dout(dout), .oen_req(oen_req), .ie(ie), .pg(pg),
    .deb_en(deb_en), .deb_thresh(deb_thresh), .pad_c(pad_c),
    .pad_i(pi), .pad_oen(po), .pad_ie(pe), .din(dn), .rise(ri), .fall(fa));

  pb_bank_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEB_W(4), .TURN_CYC(1)) u1 (
    .clk(clk), .rst(rst), .dout(dout), .oen_req(oen_req), .ie(ie), .pg(pg),
    .deb_en(deb_en), .deb_thresh(deb_thresh), .pad_c(pad_c),
    .pad_i(pi1), .pad_oen(po1), .pad_ie(pe1), .din(dn1), .rise(ri1), .fall(fa1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_tick();
    logic [7:0] nd;
    m_pi  = dout;
    m_pie = ie & {8{pg}};
    for (int c = 0; c < 8; c++) begin
      if (!pg) begin
        m_st[c] = 0;
        m_tc[c] = 0;
      end else if (m_st[c] == 0) begin
        if (!oen_req[c]) begin
          m_st[c] = 1;
          m_tc[c] = 0;
        end
      end else if (m_st[c] == 1) begin
        if (m_tc[c] == 2) begin
          m_st[c] = oen_req[c] ? 0 : 2;
          m_tc[c] = 0;
        end else m_tc[c]++;
      end else if (oen_req[c]) begin
        m_st[c] = 1;
        m_tc[c] = 0;
      end
      m_oen[c] = m_st[c] != 2;
      if (!deb_en || deb_thresh == 0) begin
        nd[c] = m_s1[c];
        m_cnt[c] = 0;
      end else if (m_s1[c] == m_din[c]) begin
        nd[c] = m_din[c];
        m_cnt[c] = 0;
      end else if (m_cnt[c] == 4'(deb_thresh - 1)) begin
        nd[c] = m_s1[c];
        m_cnt[c] = 0;
      end else begin
        nd[c] = m_din[c];
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
    m_rise = nd & ~m_din;
    m_fall = ~nd & m_din;
    m_din  = nd;
    m_s1   = m_s0;
    m_s0   = pad_c;
  endtask

  initial begin
    // asynchronous reset with drive requested everywhere
    #1 rst = 1;
    #1;
    chk("rst_oen1", po1, 8'hff);
    chk("rst_oen3", po, 8'hff);
    chk("rst_pi", pi1, 8'h00);
    chk("rst_ie", pe1, 8'h00);
    chk("rst_din", dn1, 8'h00);
    #6 rst = 0;
    step();
    chk("rel_e1_oen1", po1, 8'hff);
    chk("rel_e1_pi", pi1, 8'hff);
    chk("rel_e1_ie", pe1, 8'hff);
    step();
    chk("rel_e2_oen1", po1, 8'h00);
    chk("rel_e2_oen3", po, 8'hff);
    step();
    chk("rel_e3_oen3", po, 8'hff);
    step();
    chk("rel_e4_oen3", po, 8'h00);
    // mid-operation asynchronous reset
    #3 rst = 1;
    #1;
    chk("mid_rst_oen1", po1, 8'hff);
    chk("mid_rst_oen3", po, 8'hff);
    chk("mid_rst_pi", pi, 8'h00);
    chk("mid_rst_ie", pe, 8'h00);
    rst = 0;
    oen_req = 8'hff;
    step();
    chk("after_rst_oen3", po, 8'hff);
    chk("after_rst_pi", pi, 8'hff);
    // turnaround on channel 0 with TURN_CYC=3
    oen_req = 8'hfe;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("drive_e%0d", j), {7'b0, po[0]}, j < 3 ? 8'h01 : 8'h00);
    end
    chk("drive_others", po[7:1], 7'h7f);
    oen_req = 8'hff;
    step();
    chk("release_imm", {7'b0, po[0]}, 8'h01);
    oen_req = 8'hfe;
    step();
    chk("toggle_a1", {7'b0, po[0]}, 8'h01);
    oen_req = 8'hff;
    step();
    chk("toggle_a2", {7'b0, po[0]}, 8'h01);
    oen_req = 8'hfe;
    step();
    chk("toggle_a_out", {7'b0, po[0]}, 8'h00);
    oen_req = 8'hff;
    step();
    chk("toggle_b0", {7'b0, po[0]}, 8'h01);
    oen_req = 8'hfe;
    step();
    chk("toggle_b1", {7'b0, po[0]}, 8'h01);
    oen_req = 8'hff;
    step();
    chk("toggle_b2", {7'b0, po[0]}, 8'h01);
    step();
    chk("toggle_b_in", {7'b0, po[0]}, 8'h01);
    step();
    chk("toggle_b_stay", {7'b0, po[0]}, 8'h01);
    // output data path
    dout = 8'h5a;
    step();
    chk("dout_pi3", pi, 8'h5a);
    chk("dout_pi1", pi1, 8'h5a);
    // debounce, threshold 4: a 3-cycle glitch is rejected
    deb_en = 1;
    deb_thresh = 4;
    step();
    step();
    pad_c = 8'h02;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 3) pad_c = 8'h00;
      chk($sformatf("glitch_din_%0d", j), dn, 8'h00);
      chk($sformatf("glitch_rise_%0d", j), ri, 8'h00);
    end
    // 4-cycle high is accepted, then the fall is accepted too
    pad_c = 8'h02;
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j == 4) pad_c = 8'h00;
      chk($sformatf("deb_din_%0d", j), dn, (j >= 6 && j <= 9) ? 8'h02 : 8'h00);
      chk($sformatf("deb_rise_%0d", j), ri, j == 6 ? 8'h02 : 8'h00);
      chk($sformatf("deb_fall_%0d", j), fa, j == 10 ? 8'h02 : 8'h00);
    end
    // bypass: single-cycle pulse passes straight through
    deb_en = 0;
    step();
    pad_c = 8'h04;
    for (int j = 1; j <= 5; j++) begin
      step();
      pad_c = 8'h00;
      chk($sformatf("byp_din_%0d", j), dn, j == 3 ? 8'h04 : 8'h00);
      chk($sformatf("byp_rise_%0d", j), ri, j == 3 ? 8'h04 : 8'h00);
      chk($sformatf("byp_fall_%0d", j), fa, j == 4 ? 8'h04 : 8'h00);
    end
    // power-good drop with all channels driving
    oen_req = 8'h00;
    repeat (4) step();
    chk("pg_pre_oen3", po, 8'h00);
    chk("pg_pre_oen1", po1, 8'h00);
    pg = 0;
    step();
    chk("pg0_oen3", po, 8'hff);
    chk("pg0_oen1", po1, 8'hff);
    chk("pg0_ie", pe, 8'h00);
    step();
    chk("pg0b_oen3", po, 8'hff);
    pg = 1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("pg1_oen3_%0d", j), po, j == 4 ? 8'h00 : 8'hff);
      chk($sformatf("pg1_oen1_%0d", j), po1, j >= 2 ? 8'h00 : 8'hff);
      chk($sformatf("pg1_ie_%0d", j), pe, 8'hff);
      chk($sformatf("pg1_din_%0d", j), dn, 8'h00);
    end
    // random traffic against a reference model, starting from a fresh reset
    #2 rst = 1;
    #1 rst = 0;
    for (int c = 0; c < 8; c++) begin
      m_st[c] = 0;
      m_tc[c] = 0;
      m_cnt[c] = 0;
      run[c] = 0;
    end
    m_oen = 8'hff;
    m_pi = 0;
    m_pie = 0;
    m_din = 0;
    m_rise = 0;
    m_fall = 0;
    m_s0 = 0;
    m_s1 = 0;
    prev_oen = 8'hff;
    deb_thresh = 3;
    for (int n = 0; n < 400; n++) begin
      dout = 8'($urandom);
      ie = 8'($urandom);
      oen_req = oen_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      pad_c = pad_c ^ (8'($urandom) & 8'($urandom));
      pg = $urandom_range(0, 15) != 0;
      deb_en = $urandom_range(0, 7) != 0;
      model_tick();
      step();
      chk("rnd_pi", pi, m_pi);
      chk("rnd_oen", po, m_oen);
      chk("rnd_ie", pe, m_pie);
      chk("rnd_din", dn, m_din);
      chk("rnd_rise", ri, m_rise);
      chk("rnd_fall", fa, m_fall);
      for (int c = 0; c < 8; c++) begin
        if (po[c]) run[c]++;
        else begin
          if (prev_oen[c]) chk($sformatf("turn_gap_ch%0d", c), {7'b0, run[c] >= 3}, 8'h01);
          run[c] = 0;
        end
      end
      prev_oen = po;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
